// File: rtl/dct_block_arbiter_pkg.sv
// Shared types and helpers for the DCT block arbiter: FSM state encoding,
// default block height and the round-robin winner selection.
package dct_pkg;

  localparam int          ROWS_PER_BLK = 8;
  localparam int unsigned RR_MAX       = 32;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_LOCK = 1'b1
  } arb_state_t;

  // First valid index strictly after 'last', wrapping modulo n.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned       last,
                                          input int unsigned       n);
    int unsigned       win;
    int unsigned       idx;
    logic              found;
    logic [RR_MAX-1:0] sh;
    win   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = (last + k) % n;
      sh  = valid >> idx;
      if (!found && (k <= n) && sh[0]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dct_block_arbiter_if.sv
// Handshake bundle between block sources, the arbiter and the DCT core.
// slave = arbiter side, master = sources/core side.
interface dct_block_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int IN_W  = 32,
  parameter int ROWS  = 8
);
  localparam int ROW_W = IN_W * ROWS;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*ROW_W-1:0] req_row;
  logic [N_REQ-1:0]       req_ready;
  logic                   core_in_valid;
  logic [ROW_W-1:0]       core_in_row;
  logic                   core_in_ready;
  logic                   core_out_valid;
  logic [ROW_W-1:0]       core_out_row;
  logic                   core_out_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [ROW_W-1:0]       rsp_row;
  logic [N_REQ-1:0]       rsp_ready;

  modport slave (
    input  req_valid, req_row, core_in_ready, core_out_valid, core_out_row, rsp_ready,
    output req_ready, core_in_valid, core_in_row, core_out_ready, rsp_valid, rsp_row
  );

  modport master (
    output req_valid, req_row, core_in_ready, core_out_valid, core_out_row, rsp_ready,
    input  req_ready, core_in_valid, core_in_row, core_out_ready, rsp_valid, rsp_row
  );

endinterface

// File: rtl/dct_block_arbiter_tag_fifo.sv
// Owner-tag FIFO: one entry per block granted into the DCT core, popped when
// that block's last output row has been delivered.
module dct_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int N_REQ = 3,
  parameter int W     = $clog2(N_REQ),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_tag,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (32'(count_q) == DEPTH);
  assign empty = (count_q == '0);

endmodule

// File: rtl/dct_block_arbiter.sv
// Block-granular round-robin sharing of one row-streaming DCT core, with
// response routing by owner tag. Optional counters under `DCT_ARB_PERF_EN.
module dct_block_arbiter
  import dct_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int IN_W      = 32,
  parameter int ROWS      = ROWS_PER_BLK,
  parameter int TAG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dct_block_arbiter_if.slave   bus,
  output logic                 proto_err
`ifdef DCT_ARB_PERF_EN
  ,
  output logic [N_REQ*16-1:0]  blk_cnt,
  output logic [31:0]          stall_cyc
`endif
);
  localparam int ROW_W = IN_W * ROWS;
  localparam int GW    = $clog2(N_REQ);
  localparam int CW    = $clog2(ROWS + 1);
  localparam int TCW   = $clog2(TAG_DEPTH + 1);

  arb_state_t     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]  in_cnt_q, in_cnt_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic           proto_err_q, proto_err_d;

  logic           tag_push, tag_pop, tag_full, tag_empty, tag_room;
  logic [GW-1:0]  tag_head, winner;
  logic [TCW-1:0] tag_count;
  logic           in_beat, out_beat;

  dct_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .N_REQ (N_REQ)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (grant_d),
    .pop      (tag_pop),
    .head     (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign tag_room = !tag_full && (32'(tag_count) < TAG_DEPTH);
  assign winner   = GW'(rr_pick(RR_MAX'(bus.req_valid), 32'(last_grant_q), N_REQ));

  // Input side: one bubble cycle to grant, then the block is locked to grant_q.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    in_cnt_d          = in_cnt_q;
    tag_push          = 1'b0;
    in_beat           = 1'b0;
    bus.req_ready     = '0;
    bus.core_in_valid = 1'b0;
    bus.core_in_row   = '0;
    case (state_q)
      A_IDLE: begin
        if ((|bus.req_valid) && tag_room) begin
          grant_d  = winner;
          tag_push = 1'b1;
          in_cnt_d = '0;
          state_d  = A_LOCK;
        end
      end
      A_LOCK: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == GW'(i)) begin
            bus.core_in_valid = bus.req_valid[i];
            bus.core_in_row   = bus.req_row[i*ROW_W +: ROW_W];
            bus.req_ready[i]  = bus.core_in_ready;
          end
        end
        in_beat = bus.core_in_valid && bus.core_in_ready;
        if (in_beat) begin
          if (in_cnt_q == CW'(ROWS - 1)) begin
            in_cnt_d     = '0;
            last_grant_d = grant_q;
            state_d      = A_IDLE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  // Output side: route core rows to the owner at the tag FIFO head.
  always_comb begin
    out_cnt_d          = out_cnt_q;
    proto_err_d        = proto_err_q;
    tag_pop            = 1'b0;
    out_beat           = 1'b0;
    bus.rsp_valid      = '0;
    bus.rsp_row        = '0;
    bus.core_out_ready = 1'b0;
    if (!tag_empty) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_head == GW'(i)) begin
          bus.rsp_valid[i]   = bus.core_out_valid;
          bus.core_out_ready = bus.rsp_ready[i];
        end
      end
      bus.rsp_row = bus.core_out_row;
      out_beat    = bus.core_out_valid && bus.core_out_ready;
      if (out_beat) begin
        if (out_cnt_q == CW'(ROWS - 1)) begin
          out_cnt_d = '0;
          tag_pop   = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
    end else if (bus.core_out_valid) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= A_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

`ifdef DCT_ARB_PERF_EN
  logic [N_REQ*16-1:0] blk_cnt_q, blk_cnt_d;
  logic [31:0]         stall_cyc_q, stall_cyc_d;

  always_comb begin
    blk_cnt_d   = blk_cnt_q;
    stall_cyc_d = stall_cyc_q;
    if (tag_pop) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_head == GW'(i)) begin
          blk_cnt_d[i*16 +: 16] = blk_cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
    if (bus.core_in_valid && !bus.core_in_ready) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
// Scoreboard bench for dct_block_arbiter: random block traffic through a
// behavioural core, plus directed full-FIFO, protocol-error and reset cases.
`timescale 1ns/1ps
module tb_dct_block_arbiter;
  import dct_pkg::*;

  localparam int N_REQ     = 3;
  localparam int IN_W      = 32;
  localparam int ROWS      = 8;
  localparam int TAG_DEPTH = 2;
  localparam int ROW_W     = IN_W * ROWS;
  localparam int MAX_BLK   = 5;

  typedef struct {
    int               owner;
    logic [ROW_W-1:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic proto_err;
  always #5 clk = ~clk;

  dct_block_arbiter_if #(.N_REQ(N_REQ), .IN_W(IN_W), .ROWS(ROWS)) bus ();

`ifdef DCT_ARB_PERF_EN
  logic [N_REQ*16-1:0] blk_cnt;
  logic [31:0]         stall_cyc;
`endif

  dct_block_arbiter #(
    .N_REQ(N_REQ), .IN_W(IN_W), .ROWS(ROWS), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .proto_err (proto_err)
`ifdef DCT_ARB_PERF_EN
    ,
    .blk_cnt   (blk_cnt),
    .stall_cyc (stall_cyc)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [ROW_W-1:0] row_mem [N_REQ][MAX_BLK*ROWS];
  int               total_rows [N_REQ];
  int               sent [N_REQ];
  exp_t             exp_in[$];
  exp_t             exp_out[$];
  logic [ROW_W-1:0] core_q[$];
  int               blocks_started = 0;
  int               blocks_done = 0;
  int               in_beats = 0;
  int               out_beats = 0;
  int               done_per [N_REQ];
  int               stall_model = 0;
  bit               mon_en = 1'b0;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_core_in_valid"}, bus.core_in_valid, 0);
    chk({tag, "_core_in_row"}, bus.core_in_row, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_core_out_ready"}, bus.core_out_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_row"}, bus.rsp_row, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
`ifdef DCT_ARB_PERF_EN
    chk({tag, "_blk_cnt"}, blk_cnt, 0);
    chk({tag, "_stall_cyc"}, stall_cyc, 0);
`endif
  endtask

  task automatic clear_inputs();
    bus.req_valid      = '0;
    bus.req_row        = '0;
    bus.core_in_ready  = 1'b0;
    bus.core_out_valid = 1'b0;
    bus.core_out_row   = '0;
    bus.rsp_ready      = '0;
  endtask

  // Reference: each source holds valid between its blocks, so the grant order
  // is round robin over the sources that still have blocks left.
  task automatic build_model();
    int rem [N_REQ];
    int last;
    int pick;
    int left;
    left = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rem[i]        = $urandom_range(2, MAX_BLK);
      total_rows[i] = rem[i] * ROWS;
      sent[i]       = 0;
      done_per[i]   = 0;
      left         += rem[i];
      for (int r = 0; r < total_rows[i]; r++) begin
        row_mem[i][r] = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
      end
    end
    last = N_REQ - 1;
    while (left > 0) begin
      pick = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        if (pick < 0 && rem[(last + k) % N_REQ] > 0) pick = (last + k) % N_REQ;
      end
      for (int r = 0; r < ROWS; r++) begin
        int idx;
        exp_t e;
        idx     = sent[pick] + r;
        e.owner = pick;
        e.row   = row_mem[pick][idx];
        exp_in.push_back(e);
        e.row   = ~row_mem[pick][idx];
        exp_out.push_back(e);
      end
      sent[pick] += ROWS;
      rem[pick]--;
      left--;
      last = pick;
    end
    for (int i = 0; i < N_REQ; i++) sent[i] = 0;
  endtask

  task automatic drive_random(input bit hold_rsp);
    for (int i = 0; i < N_REQ; i++) begin
      if (sent[i] < total_rows[i]) begin
        bus.req_valid[i] = (sent[i] % ROWS == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.req_row[i*ROW_W +: ROW_W] = row_mem[i][sent[i]];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_row[i*ROW_W +: ROW_W] = '0;
      end
      bus.rsp_ready[i] = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    bus.core_in_ready = ($urandom_range(0, 3) != 0);
    if (core_q.size() > 0) begin
      bus.core_out_valid = ($urandom_range(0, 3) != 0);
      bus.core_out_row   = ~core_q[0];
    end else begin
      bus.core_out_valid = 1'b0;
      bus.core_out_row   = '0;
    end
  endtask

  task automatic account();
    logic [ROW_W-1:0] tmp;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) sent[i]++;
    end
    if (bus.core_out_valid && bus.core_out_ready && core_q.size() > 0) tmp = core_q.pop_front();
    if (bus.core_in_valid && bus.core_in_ready) core_q.push_back(bus.core_in_row);
  endtask

  task automatic run_cycle(input bit hold_rsp);
    @(posedge clk);
    #1;
    drive_random(hold_rsp);
    @(negedge clk);
    account();
  endtask

  // Monitor: pops the scoreboard on every core input and response beat.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [N_REQ-1:0] oh;
        exp_t e;
        chk("req_ready_onehot", ($countones(bus.req_ready) <= 1), 1);
        chk("rsp_valid_onehot", ($countones(bus.rsp_valid) <= 1), 1);
        if (bus.core_in_valid && !bus.core_in_ready) stall_model++;
        if (bus.core_in_valid && bus.core_in_ready) begin
          if (exp_in.size() == 0) begin
            chk("in_unexpected_beat", 1, 0);
          end else begin
            e  = exp_in.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            chk("in_row", bus.core_in_row, e.row);
            chk("in_owner_ready", bus.req_ready, oh);
            if (in_beats % ROWS == 0) begin
              chk("tag_depth_limit", ((blocks_started - blocks_done) < TAG_DEPTH), 1);
              blocks_started++;
            end
            in_beats++;
          end
        end
        if (bus.core_out_valid && bus.core_out_ready) begin
          if (exp_out.size() == 0) begin
            chk("out_unexpected_beat", 1, 0);
          end else begin
            e  = exp_out.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            chk("rsp_owner", bus.rsp_valid, oh);
            chk("rsp_row", bus.rsp_row, e.row);
            out_beats++;
            if (out_beats % ROWS == 0) begin
              blocks_done++;
              done_per[e.owner]++;
            end
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int beats;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    build_model();
    mon_en = 1'b1;

    // Responses held off: the tag FIFO fills and further grants stop.
    for (int c = 0; c < 100; c++) run_cycle(1'b1);
    @(posedge clk);
    #1;
    chk("full_blocks_in_flight", blocks_started - blocks_done, TAG_DEPTH);
    chk("full_no_req_ready", bus.req_ready, 0);

    cyc = 0;
    while ((exp_out.size() > 0 || exp_in.size() > 0) && cyc < 20000) begin
      run_cycle(1'b0);
      cyc++;
    end
    chk("random_run_within_budget", (cyc < 20000), 1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    for (int i = 0; i < N_REQ; i++) chk("all_rows_sent", sent[i], total_rows[i]);
    chk("no_proto_err_in_traffic", proto_err, 0);
`ifdef DCT_ARB_PERF_EN
    for (int i = 0; i < N_REQ; i++) chk("perf_blk_cnt", blk_cnt[i*16 +: 16], 16'(done_per[i]));
    chk("perf_stall_cyc", stall_cyc, stall_model);
`endif
    clear_inputs();

    // Core output with nothing in flight.
    @(posedge clk);
    #1;
    bus.core_out_valid = 1'b1;
    bus.core_out_row   = {8{32'hdeadbeef}};
    bus.rsp_ready      = '1;
    #1;
    chk("proto_core_out_ready", bus.core_out_ready, 0);
    chk("proto_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    bus.core_out_valid = 1'b0;
    chk("proto_err_set", proto_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("proto_err_sticky", proto_err, 1);

    // Reset in the middle of a block from source 0.
    bus.req_valid     = 3'b001;
    bus.req_row       = '0;
    bus.req_row[0 +: ROW_W] = {8{32'h0000_0004}};
    bus.core_in_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) beats++;
    end
    chk("mid_block_beats_reached", beats, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    check_outputs_zero("reset_held");

    // After reset, last grant is N_REQ-1, so source 0 beats source 1.
    bus.req_valid = 3'b011;
    bus.req_row[ROW_W +: ROW_W] = {8{32'h0000_0011}};
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_grant_ready", bus.req_ready, 3'b001);
    chk("post_reset_core_in_valid", bus.core_in_valid, 1);
    chk("post_reset_core_in_row", bus.core_in_row, {8{32'h0000_0004}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
